// File: rtl/mem_ctrl.sv
// Controller between the core memory port and an asynchronous 16-bit SRAM.
// Produces timed CE/OE/WE strobes with programmable wait states and a data_ready pulse.
module mem_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              data_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_in,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  input  logic              ram_wait
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              data_ready_q, data_ready_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_dq_out_q, ram_dq_out_d;
  logic              ram_dq_oe_q, ram_dq_oe_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic              ram_we_n_q, ram_we_n_d;

  // Every output is a flop loaded with the value of the state being entered,
  // so strobes line up with the state they belong to without input-to-output paths.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    data_ready_d = 1'b0;
    busy_d       = busy_q;
    ram_addr_d   = ram_addr_q;
    ram_dq_out_d = ram_dq_out_q;
    ram_dq_oe_d  = ram_dq_oe_q;
    ram_ce_n_d   = ram_ce_n_q;
    ram_oe_n_d   = ram_oe_n_q;
    ram_we_n_d   = ram_we_n_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = SETUP;
          we_d       = we;
          busy_d     = 1'b1;
          ram_addr_d = addr;
          ram_ce_n_d = 1'b0;
          ram_oe_n_d = 1'b1;
          ram_we_n_d = 1'b1;
          if (we) begin
            ram_dq_out_d = wdata;
            ram_dq_oe_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        cnt_d      = CNT_LOAD;
        ram_oe_n_d = we_q;
        ram_we_n_d = ~we_q;
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!ram_wait) begin
          state_d      = DONE;
          data_ready_d = 1'b1;
          ram_ce_n_d   = 1'b1;
          ram_oe_n_d   = 1'b1;
          ram_we_n_d   = 1'b1;
          if (!we_q) rdata_d = ram_dq_in;
        end
      end
      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        ram_dq_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_dq_out_q <= '0;
      ram_dq_oe_q  <= 1'b0;
      ram_ce_n_q   <= 1'b1;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      ram_addr_q   <= ram_addr_d;
      ram_dq_out_q <= ram_dq_out_d;
      ram_dq_oe_q  <= ram_dq_oe_d;
      ram_ce_n_q   <= ram_ce_n_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign ram_dq_out = ram_dq_out_q;
  assign ram_dq_oe  = ram_dq_oe_q;
  assign ram_ce_n   = ram_ce_n_q;
  assign ram_oe_n   = ram_oe_n_q;
  assign ram_we_n   = ram_we_n_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU core's memory port (address, write data, write enable) and an external asynchronous 16-bit SRAM-style memory.
- Turns one-cycle-view core requests into properly timed chip-enable, output-enable and write-enable sequences with programmable wait states.
- Returns a one-cycle data_ready pulse, which the core's Fetch and Memory states wait on.

Parameters:
- WAIT_CYCLES, 3, number of ACCESS cycles with OE_n/WE_n asserted; legal range 1..15.
- ADDR_W, 24, address width, matching the core's mem_address.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  core request, level; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched when the request is accepted.
- addr  in  ADDR_W  word address; latched when the request is accepted.
- wdata  in  DATA_W  write data; latched when the request is accepted.
- rdata  out  DATA_W  read data, registered; valid from the data_ready cycle onward.
- data_ready  out  1  one-cycle pulse at completion of a read or a write.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  ADDR_W  memory address, registered.
- ram_dq_out  out  DATA_W  data driven to memory.
- ram_dq_oe  out  1  tristate enable for ram_dq_out.
- ram_dq_in  in  DATA_W  data from memory.
- ram_ce_n  out  1  chip enable, active low.
- ram_oe_n  out  1  output enable, active low.
- ram_we_n  out  1  write enable, active low.
- ram_wait  in  1  memory wait, active high; extends ACCESS.

Behaviour:
- Reset values: rdata=0, data_ready=0, busy=0, ram_addr=0, ram_dq_out=0, ram_dq_oe=0, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, state=IDLE, wait counter=0.
- Reset mid-transaction: at the next edge, go to IDLE with all of the above values. No data_ready pulse; no partial rdata update.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - All strobes are inactive.
  - If req=1 at an edge: latch we, addr and wdata; go to SETUP.
- SETUP (1 cycle):
  - ram_ce_n=0, ram_addr=latched addr, ram_oe_n=1, ram_we_n=1.
  - For a write, ram_dq_oe=1 and ram_dq_out=latched wdata.
  - Load the counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - ram_ce_n=0; ram_oe_n=0 for a read, ram_we_n=0 for a write.
  - Decrement the counter each cycle.
  - Leave only when counter==0 and ram_wait==0. While ram_wait=1 at counter 0, stay with the counter held at 0.
  - On exit from a read, rdata <= ram_dq_in, sampled at the same edge. Go to DONE.
- DONE (1 cycle):
  - ram_ce_n=1, ram_oe_n=1, ram_we_n=1, data_ready=1.
  - For a write, ram_dq_oe stays 1 for this cycle (data hold), then drops to 0 on return to IDLE.
  - Go to IDLE.
- Latency with ram_wait=0: req sampled at edge 0 → data_ready high between edges WAIT_CYCLES+1 and WAIT_CYCLES+2. Default: 4 edges to DONE; busy for 5 cycles.
- Core protocol:
  - The core holds req until it sees data_ready, then drops it or re-asserts it for the next transaction.
  - req seen during DONE is ignored. Back-to-back: a new request is accepted at the first IDLE edge.
- rdata keeps the last read value across writes and idle periods.
- Changes to we, addr or wdata after acceptance have no effect on the transaction in flight.
- ram_addr keeps its last value in IDLE (no glitching to 0).
- ram_we_n and ram_oe_n are never low at the same time. ram_dq_oe is never 1 while ram_oe_n=0.

Test Plan:
1. Reset, then read: req=1, we=0, addr=24'h002400, ram model returns 16'hBEEF after OE_n falls.
   → SETUP 1 cycle, then OE_n low for 3 cycles, then data_ready for 1 cycle with rdata=16'hBEEF; busy for 5 cycles; WE_n stays 1 throughout.
2. Write: addr=24'h000010, wdata=16'h1234.
   → WE_n low for exactly 3 cycles; dq_oe=1 from SETUP through DONE with ram_dq_out=16'h1234; model memory[0x10]=16'h1234; rdata unchanged from scenario 1.
3. Read with ram_wait held high for 2 cycles after the counter reaches 0.
   → ACCESS lasts 5 cycles; data_ready arrives 2 cycles later than in scenario 1 with the correct data.
4. Back-to-back: write then read of the same address, with req re-asserted in the data_ready cycle.
   → Second transaction starts at the following IDLE edge; read returns the written value; no spurious third access.
5. Assert reset during the 2nd ACCESS cycle of a write.
   → Next edge: CE_n=WE_n=OE_n=1, dq_oe=0, busy=0; no data_ready pulse; rdata=0.
6. Set WAIT_CYCLES=1 and change addr/wdata the cycle after acceptance.
   → Exactly one ACCESS cycle; the original latched addr and data are used.
